forwarding_control: RTL and testbench

Hazard and forwarding controller for the LC-3b EX stage. Tracks destination-register information for the instructions in EX and MEM in its own shadow pipeline. When the instruction in ID moves into EX, it registers the EX operand-forwarding mux selects. It detects load-use hazards, stalls IF/ID for one cycle and injects a bubble into ID/EX. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and is driven by the same global stall and branch flush.

---
 rtl/forwarding_control_pkg.sv | 37 +++
 rtl/forwarding_control_hazard_entry_reg.sv | 25 ++
 rtl/forwarding_control.sv | 86 ++++++++
 tb/tb_forwarding_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/forwarding_control_pkg.sv
// LC-3b register, hazard-entry and forwarding-select types shared by the EX-stage
// hazard/forwarding controller; also holds the select function reused for both operands.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2
  } lc3b_forward_EX_mux_sel;

  typedef struct packed {
    logic    valid;
    lc3b_reg dest;
    logic    we;
    logic    load;
  } lc3b_hazard_entry;

  function automatic logic entry_hit(lc3b_hazard_entry e, lc3b_reg r);
    return e.valid & e.we & (e.dest == r);
  endfunction

  // The EX shadow holds the younger producer, so it is checked before MEM.
  function automatic lc3b_forward_EX_mux_sel fwd_sel(logic bubble, logic used, lc3b_reg src,
                                                     lc3b_hazard_entry ex_e,
                                                     lc3b_hazard_entry mem_e);
    lc3b_forward_EX_mux_sel sel;
    sel = FWD_REGFILE;
    if (!bubble && used) begin
      if (entry_hit(ex_e, src)) sel = FWD_MEM;
      else if (entry_hit(mem_e, src)) sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/forwarding_control_hazard_entry_reg.sv
// One shadow-pipeline slot: 1-cycle register, frozen while stall is high,
// cleared synchronously by clear (which overrides stall).
module hazard_entry_reg
  import lc3b_types::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic             stall,
  input  lc3b_hazard_entry d,
  output lc3b_hazard_entry q
);

  lc3b_hazard_entry entry_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      entry_q <= '0;
    end else if (!stall) begin
      entry_q <= d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/forwarding_control.sv
// LC-3b EX-stage hazard/forwarding control: selects registered one cycle after ID, load-use
// stall is combinational; the global stall freezes all state while load_use_stall is still evaluated.
module forwarding_control
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   id_valid,
  input  lc3b_reg                id_sr1,
  input  lc3b_reg                id_sr2,
  input  logic                   id_sr1_used,
  input  logic                   id_sr2_used,
  input  lc3b_reg                id_dest,
  input  logic                   id_regfile_we,
  input  logic                   id_is_load,
  output lc3b_forward_EX_mux_sel forward_EX_A_mux_sel,
  output lc3b_forward_EX_mux_sel forward_EX_B_mux_sel,
  output logic                   load_use_stall,
  output logic [CNT_W-1:0]       perf_load_use_count
);

  lc3b_hazard_entry       ex_q, ex_d, mem_q;
  lc3b_forward_EX_mux_sel sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   lu_hazard;
  logic                   bubble;

  always_comb begin
    lu_hazard = id_valid & ~flush & ex_q.valid & ex_q.load & ex_q.we &
                ((id_sr1_used & (ex_q.dest == id_sr1)) |
                 (id_sr2_used & (ex_q.dest == id_sr2)));
    bubble    = flush | lu_hazard | ~id_valid;

    ex_d = '0;
    if (!bubble) begin
      ex_d.valid = 1'b1;
      ex_d.dest  = id_dest;
      ex_d.we    = id_regfile_we;
      ex_d.load  = id_is_load;
    end

    sel_a_d = fwd_sel(bubble, id_sr1_used, id_sr1, ex_q, mem_q);
    sel_b_d = fwd_sel(bubble, id_sr2_used, id_sr2, ex_q, mem_q);

    cnt_d = cnt_q;
    if (lu_hazard && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  hazard_entry_reg u_ex_entry (
    .clk   (clk),
    .clear (reset),
    .stall (stall),
    .d     (ex_d),
    .q     (ex_q)
  );

  hazard_entry_reg u_mem_entry (
    .clk   (clk),
    .clear (reset),
    .stall (stall),
    .d     (ex_q),
    .q     (mem_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_a_q <= FWD_REGFILE;
      sel_b_q <= FWD_REGFILE;
      cnt_q   <= '0;
    end else if (!stall) begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign forward_EX_A_mux_sel = sel_a_q;
  assign forward_EX_B_mux_sel = sel_b_q;
  assign load_use_stall       = lu_hazard;
  assign perf_load_use_count  = cnt_q;

endmodule

// File: tb/tb_forwarding_control.sv
// Directed-vector bench for forwarding_control; counter width reduced so saturation is reachable quickly.
module tb_forwarding_control;
  import lc3b_types::*;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  logic clk = 1'b0;
  logic reset, stall, flush;
  logic id_valid, id_sr1_used, id_sr2_used, id_regfile_we, id_is_load;
  logic [2:0] id_sr1, id_sr2, id_dest;
  lc3b_forward_EX_mux_sel sel_a, sel_b;
  logic lus;
  logic [CNT_W-1:0] cnt;

  int n_cmp = 0;
  int n_fail = 0;

  forwarding_control #(.CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .stall                (stall),
    .flush                (flush),
    .id_valid             (id_valid),
    .id_sr1               (id_sr1),
    .id_sr2               (id_sr2),
    .id_sr1_used          (id_sr1_used),
    .id_sr2_used          (id_sr2_used),
    .id_dest              (id_dest),
    .id_regfile_we        (id_regfile_we),
    .id_is_load           (id_is_load),
    .forward_EX_A_mux_sel (sel_a),
    .forward_EX_B_mux_sel (sel_b),
    .load_use_stall       (lus),
    .perf_load_use_count  (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2, input logic [2:0] d,
                       input logic we, input logic ld);
    id_valid = v; id_sr1 = s1; id_sr1_used = u1; id_sr2 = s2; id_sr2_used = u2;
    id_dest = d; id_regfile_we = we; id_is_load = ld;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic drain;
    idle(); tick(); tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL reset_sel_a: got %0d expected 0", sel_a); end
    n_cmp++; if (sel_b !== 2'd0) begin n_fail++; $display("FAIL reset_sel_b: got %0d expected 0", sel_b); end
    n_cmp++; if (lus !== 1'b0) begin n_fail++; $display("FAIL reset_lus: got %0b expected 0", lus); end
    n_cmp++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
  endtask

  // ADD R1 <- R2,R3 then ADD R2 <- R1,R3
  task automatic test_alu_forward;
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0);
    n_cmp++; if (lus !== 1'b0) begin n_fail++; $display("FAIL alu_lus: got %0b expected 0", lus); end
    tick();
    n_cmp++; if (sel_a !== 2'd1) begin n_fail++; $display("FAIL alu_sel_a: got %0d expected 1", sel_a); end
    n_cmp++; if (sel_b !== 2'd0) begin n_fail++; $display("FAIL alu_sel_b: got %0d expected 0", sel_b); end
    drain();
    n_cmp++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL drain_sel_a: got %0d expected 0", sel_a); end
  endtask

  // ADD R1, non-writing instruction, ADD R2 <- R4,R1
  task automatic test_mem_forward;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd4, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0);
    tick();
    n_cmp++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL mem_sel_a: got %0d expected 0", sel_a); end
    n_cmp++; if (sel_b !== 2'd2) begin n_fail++; $display("FAIL mem_sel_b: got %0d expected 2", sel_b); end
    drain();
  endtask

  // LDR R1 then ADD R2 <- R1,R1
  task automatic test_load_use;
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0);
    n_cmp++; if (lus !== 1'b1) begin n_fail++; $display("FAIL lu_lus_k: got %0b expected 1", lus); end
    tick();
    n_cmp++; if (lus !== 1'b0) begin n_fail++; $display("FAIL lu_lus_k1: got %0b expected 0", lus); end
    n_cmp++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL lu_bubble_sel_a: got %0d expected 0", sel_a); end
    n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL lu_cnt_k1: got %0d expected 1", cnt); end
    tick();
    n_cmp++; if (sel_a !== 2'd2) begin n_fail++; $display("FAIL lu_sel_a: got %0d expected 2", sel_a); end
    n_cmp++; if (sel_b !== 2'd2) begin n_fail++; $display("FAIL lu_sel_b: got %0d expected 2", sel_b); end
    n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL lu_cnt_k2: got %0d expected 1", cnt); end
    drain();
  endtask

  // ADD R6, LDR R1 <- R6, then ADD R3 <- R1,R5 while stall is held for 5 cycles
  task automatic test_stall;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    n_cmp++; if (sel_a !== 2'd1) begin n_fail++; $display("FAIL st_ldr_sel_a: got %0d expected 1", sel_a); end
    stall = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (lus !== 1'b1) begin n_fail++; $display("FAIL st_lus_%0d: got %0b expected 1", i, lus); end
      tick();
      n_cmp++; if (sel_a !== 2'd1) begin n_fail++; $display("FAIL st_hold_sel_a_%0d: got %0d expected 1", i, sel_a); end
      n_cmp++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL st_hold_cnt_%0d: got %0d expected 1", i, cnt); end
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (lus !== 1'b1) begin n_fail++; $display("FAIL st_lus_release: got %0b expected 1", lus); end
    tick();
    n_cmp++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL st_cnt: got %0d expected 2", cnt); end
    n_cmp++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL st_bubble_sel_a: got %0d expected 0", sel_a); end
    tick();
    n_cmp++; if (sel_a !== 2'd2) begin n_fail++; $display("FAIL st_sel_a: got %0d expected 2", sel_a); end
    n_cmp++; if (sel_b !== 2'd0) begin n_fail++; $display("FAIL st_sel_b: got %0d expected 0", sel_b); end
    n_cmp++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL st_cnt_after: got %0d expected 2", cnt); end
    drain();
  endtask

  // Two producers of R1 then a consumer; then a flushed load-use pair
  task automatic test_priority_flush;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd7, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    n_cmp++; if (sel_a !== 2'd1) begin n_fail++; $display("FAIL pri_sel_a: got %0d expected 1", sel_a); end
    n_cmp++; if (sel_b !== 2'd0) begin n_fail++; $display("FAIL pri_sel_b: got %0d expected 0", sel_b); end
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    n_cmp++; if (lus !== 1'b0) begin n_fail++; $display("FAIL fl_lus: got %0b expected 0", lus); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL fl_sel_a: got %0d expected 0", sel_a); end
    n_cmp++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL fl_cnt: got %0d expected 2", cnt); end
    n_cmp++; if (lus !== 1'b0) begin n_fail++; $display("FAIL fl_ex_invalid: got %0b expected 0", lus); end
    tick();
    n_cmp++; if (sel_a !== 2'd2) begin n_fail++; $display("FAIL fl_next_sel_a: got %0d expected 2", sel_a); end
    drain();
  endtask

  task automatic test_reset_mid_bubble;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0);
    n_cmp++; if (lus !== 1'b1) begin n_fail++; $display("FAIL rb_lus_pre: got %0b expected 1", lus); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (sel_a !== 2'd0) begin n_fail++; $display("FAIL rb_sel_a: got %0d expected 0", sel_a); end
    n_cmp++; if (sel_b !== 2'd0) begin n_fail++; $display("FAIL rb_sel_b: got %0d expected 0", sel_b); end
    n_cmp++; if (lus !== 1'b0) begin n_fail++; $display("FAIL rb_lus: got %0b expected 0", lus); end
    n_cmp++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL rb_cnt: got %0d expected 0", cnt); end
    drain();
  endtask

  // 2^CNT_W + 3 load-use bubbles, each a LDR R1 followed by a consumer of R1
  task automatic test_saturate;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
      tick();
      drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
      tick();
      if (i == 253) begin
        n_cmp++; if (cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", cnt); end
      end
      if (i == 254) begin
        n_cmp++; if (cnt !== CNT_MAX) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", cnt); end
      end
    end
    n_cmp++; if (cnt !== CNT_MAX) begin n_fail++; $display("FAIL sat_hold: got %0d expected 255", cnt); end
    drain();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_sr1 = 3'd0; id_sr2 = 3'd0; id_sr1_used = 1'b0; id_sr2_used = 1'b0;
    id_dest = 3'd0; id_regfile_we = 1'b0; id_is_load = 1'b0;
    test_reset();
    test_alu_forward();
    test_mem_forward();
    test_load_use();
    test_stall();
    test_priority_flush();
    test_reset_mid_bubble();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
